dice_roller: RTL and testbench
==============================

DICE_ROLLER -- requirements
Module: dice_roller

Interface
REQ-001 Parameter DEB_CYCLES, default 4, meaning consecutive stable synchronized rb samples required to change the debounced level (legal range 2..15).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 rb  input  1  raw roll button, asynchronous to clk; held high to roll, released to stop.
REQ-005 die1  output  3  current value of die 1, range 1..6.
REQ-006 die2  output  3  current value of die 2, range 1..6.
REQ-007 sum  output  4  registered die1+die2 of the last completed roll, range 2..12; 0 before the first roll.
REQ-008 sum_valid  output  1  one-cycle pulse marking a new sum.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 rolls  output  8  count of completed rolls, saturating at 255.

Function
REQ-011 rb SHALL pass through a 2-flop synchronizer, then a debounce counter; debounced level rb_db SHALL change only after DEB_CYCLES consecutive synchronized samples differing from rb_db.
REQ-012 The FSM SHALL have states IDLE, ROLLING, SETTLE and PRESENT.
REQ-013 IDLE: rb_db=1 -> ROLLING; otherwise stay.
REQ-014 ROLLING: on each edge with rb_db=1, die1 SHALL advance 1->2->...->6->1; die2 SHALL advance by one only on the edge where die1 wraps 6->1.
REQ-015 ROLLING: rb_db=0 -> SETTLE; no die advance on that edge.
REQ-016 SETTLE: lasts exactly one cycle; dice frozen; sum SHALL be loaded with die1+die2 (zero-extended to 4 bits) on the edge leaving SETTLE; next state PRESENT.
REQ-017 PRESENT: lasts exactly one cycle; sum_valid=1; rolls increments unless at 255; next state IDLE.
REQ-018 sum SHALL hold its value from PRESENT until the next PRESENT.
REQ-019 Dice SHALL NOT reset between rolls; each roll resumes from the frozen values.
REQ-020 rb_db rising during SETTLE or PRESENT SHALL NOT alter sequencing; if rb_db is still 1 in IDLE, a new roll starts.
REQ-021 rb pulses shorter than DEB_CYCLES synchronized cycles SHALL produce no state change and no die advance.
REQ-022 Latency: sum_valid SHALL assert exactly 2 cycles after the first cycle in which the FSM observes rb_db=0 in ROLLING.
REQ-023 die1/die2 SHALL never take values 0 or 7.

Reset
REQ-024 rst=1 on a clock edge SHALL force: state IDLE, die1=1, die2=1, sum=0, sum_valid=0, busy=0, rolls=0, debounce counter 0, rb_db=0, synchronizer flops 0.
REQ-025 rst takes priority over all other activity, including mid-roll and in PRESENT; no sum_valid is produced for an interrupted roll.

Structure
REQ-026 Shared package dice_pkg SHALL hold the state enumeration, DIE_MIN=1, DIE_MAX=6 and the sum width (4).
REQ-027 One sub-module die_counter (mod-6 counter 1..6, inputs enable/clear, output value and wrap pulse) SHALL be instantiated twice, chained via wrap.

Verification
REQ-028 Reset, rb low 20 cycles -> die1=1, die2=1, sum=0, sum_valid never high, busy=0, rolls=0.
REQ-029 rb held for exactly 5 ROLLING advances, then released -> die1=6, die2=1, sum=7, one sum_valid pulse, rolls=1.
REQ-030 From reset, 35 advances -> die1=6, die2=6, sum=12; a further roll of 1 advance -> die1=1, die2=1, sum=2, rolls=2.
REQ-031 rb glitch high for DEB_CYCLES-1 cycles -> busy stays 0, dice unchanged, no sum_valid.
REQ-032 rst asserted while in ROLLING after 7 advances -> next cycle die1=1, die2=1, state IDLE, no sum_valid; check sum_valid 2 cycles after rb_db=0 observed in ROLLING in every other roll.
REQ-033 256 rolls -> rolls saturates at 255, sum_valid still pulses on every roll.

Source files
------------

// File: rtl/dice_pkg.sv
// Shared types and constants for the dice roller: FSM states, die range and sum width.
package dice_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ROLLING = 2'd1,
    SETTLE  = 2'd2,
    PRESENT = 2'd3
  } state_t;

  localparam int         SUM_W     = 4;
  localparam logic [2:0] DIE_MIN   = 3'd1;
  localparam logic [2:0] DIE_MAX   = 3'd6;
  localparam logic [7:0] ROLLS_MAX = 8'd255;

  function automatic logic [SUM_W-1:0] die_sum(input logic [2:0] a, input logic [2:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

endpackage

// File: rtl/die_counter.sv
// One die: counts DIE_MIN..DIE_MAX while enabled and flags the wrap back to DIE_MIN.
module die_counter
  import dice_pkg::*;
(
  input  logic       clk,
  input  logic       clear,
  input  logic       enable,
  output logic [2:0] value,
  output logic       wrap
);

  // Wrap is combinational so a chained die advances on the same edge.
  assign wrap = enable && (value >= DIE_MAX);

  always_ff @(posedge clk) begin
    if (clear) begin
      value <= DIE_MIN;
    end else if (wrap) begin
      value <= DIE_MIN;
    end else if (enable) begin
      value <= value + 3'd1;
    end
  end

endmodule

// File: rtl/dice_roller.sv
// Two-dice roller: synchronised and debounced roll button drives a four-state FSM over two chained dice.
module dice_roller
  import dice_pkg::*;
#(
  parameter int DEB_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rb,
  output logic [2:0]       die1,
  output logic [2:0]       die2,
  output logic [SUM_W-1:0] sum,
  output logic             sum_valid,
  output logic             busy,
  output logic [7:0]       rolls
);

  localparam logic [3:0] DEB_LAST = 4'(DEB_CYCLES - 1);

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == ROLLS_MAX) ? v : v + 8'd1;
  endfunction

  logic       rb_p0;
  logic       rb_p1;
  logic       rb_db;
  logic [3:0] deb_cnt;

  state_t     state;
  state_t     state_next;
  logic       advance;
  logic       die1_wrap;
  logic       die2_wrap_unused;

  // Stage p0/p1: two-flop synchroniser, then debounce on the p1 sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      rb_p0   <= 1'b0;
      rb_p1   <= 1'b0;
      rb_db   <= 1'b0;
      deb_cnt <= 4'd0;
    end else begin
      rb_p0 <= rb;
      rb_p1 <= rb_p0;
      if (rb_p1 != rb_db) begin
        if (deb_cnt == DEB_LAST) begin
          rb_db   <= rb_p1;
          deb_cnt <= 4'd0;
        end else begin
          deb_cnt <= deb_cnt + 4'd1;
        end
      end else begin
        deb_cnt <= 4'd0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    advance    = 1'b0;
    case (state)
      IDLE: begin
        if (rb_db) state_next = ROLLING;
      end
      ROLLING: begin
        if (rb_db) advance    = 1'b1;
        else       state_next = SETTLE;
      end
      SETTLE:  state_next = PRESENT;
      PRESENT: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  die_counter u_die1 (
    .clk    (clk),
    .clear  (rst),
    .enable (advance),
    .value  (die1),
    .wrap   (die1_wrap)
  );

  die_counter u_die2 (
    .clk    (clk),
    .clear  (rst),
    .enable (die1_wrap),
    .value  (die2),
    .wrap   (die2_wrap_unused)
  );

  // Sum and roll count are captured together on the edge leaving SETTLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum   <= '0;
      rolls <= 8'd0;
    end else if (state == SETTLE) begin
      sum   <= die_sum(die1, die2);
      rolls <= sat_inc(rolls);
    end
  end

  assign sum_valid = (state == PRESENT);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_dice_roller.sv
// Scoreboard bench for dice_roller: rolls push expected results, a negedge monitor checks each sum_valid.
module tb_dice_roller;

  localparam int DEB = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rb  = 1'b0;
  logic [2:0] die1;
  logic [2:0] die2;
  logic [3:0] sum;
  logic       sum_valid;
  logic       busy;
  logic [7:0] rolls;

  dice_roller #(.DEB_CYCLES(DEB)) dut (
    .clk       (clk),
    .rst       (rst),
    .rb        (rb),
    .die1      (die1),
    .die2      (die2),
    .sum       (sum),
    .sum_valid (sum_valid),
    .busy      (busy),
    .rolls     (rolls)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int sum;
    int d1;
    int d2;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   m_d1 = 1;
  int   m_d2 = 1;
  int   m_rolls = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every sum_valid must match the oldest outstanding roll.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (die1 == 3'd0 || die1 == 3'd7) check("die1_range", die1, 1);
      if (die2 == 3'd0 || die2 == 3'd7) check("die2_range", die2, 1);
      if (sum_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_sum_valid", 1, 0);
        end else begin
          e = sb.pop_front();
          check("sum_valid_cycle", cyc, e.cyc);
          check("sum", sum, e.sum);
          check("present_die1", die1, e.d1);
          check("present_die2", die2, e.d2);
          check("present_busy", busy, 1);
        end
      end
    end
  end

  task automatic model_advance(input int n);
    for (int i = 0; i < n; i++) begin
      if (m_d1 == 6) begin
        m_d1 = 1;
        m_d2 = (m_d2 == 6) ? 1 : m_d2 + 1;
      end else begin
        m_d1 = m_d1 + 1;
      end
    end
  endtask

  // Holding rb for n+1 edges gives n advances; sum_valid lands n+7 edges after rb rises.
  task automatic roll(input int n);
    exp_t e;
    int   c0;
    @(posedge clk); #1;
    rb = 1'b1;
    c0 = cyc;
    model_advance(n);
    e.cyc = c0 + n + 7;
    e.sum = m_d1 + m_d2;
    e.d1  = m_d1;
    e.d2  = m_d2;
    m_rolls = (m_rolls == 255) ? 255 : m_rolls + 1;
    sb.push_back(e);
    repeat (n + 1) @(posedge clk);
    #1 rb = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("sum_valid_seen", sb.size(), 0);
    sb.delete();
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    rb  = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    m_d1 = 1;
    m_d2 = 1;
    m_rolls = 0;
    sb.delete();
  endtask

  initial begin
    #2ms;
    $display("FAIL timeout: bench did not finish, got cycle %0d, expected completion", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    rb  = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_die1", die1, 1);
    check("rst_die2", die2, 1);
    check("rst_sum", sum, 0);
    check("rst_sum_valid", sum_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_rolls", rolls, 0);

    repeat (20) @(posedge clk);
    #1;
    check("idle20_die1", die1, 1);
    check("idle20_die2", die2, 1);
    check("idle20_sum", sum, 0);
    check("idle20_busy", busy, 0);
    check("idle20_rolls", rolls, 0);

    roll(5);
    check("r5_die1", die1, 6);
    check("r5_die2", die2, 1);
    check("r5_sum", sum, 7);
    check("r5_rolls", rolls, 1);
    check("r5_busy", busy, 0);

    do_reset();
    roll(35);
    check("r35_die1", die1, 6);
    check("r35_die2", die2, 6);
    check("r35_sum", sum, 12);
    roll(1);
    check("r1_die1", die1, 1);
    check("r1_die2", die2, 1);
    check("r1_sum", sum, 2);
    check("r1_rolls", rolls, 2);

    // Glitch shorter than the debounce window.
    @(posedge clk); #1 rb = 1'b1;
    repeat (DEB - 1) @(posedge clk);
    #1 rb = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      check("glitch_busy", busy, 0);
    end
    check("glitch_die1", die1, 1);
    check("glitch_die2", die2, 1);
    check("glitch_rolls", rolls, 2);

    // Reset mid-roll after 7 advances; no sum_valid may follow.
    @(posedge clk); #1 rb = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("mid_die1", die1, 2);
    check("mid_die2", die2, 2);
    check("mid_busy", busy, 1);
    rst = 1'b1;
    rb  = 1'b0;
    @(posedge clk); #1;
    check("midrst_die1", die1, 1);
    check("midrst_die2", die2, 1);
    check("midrst_busy", busy, 0);
    check("midrst_sum", sum, 0);
    check("midrst_rolls", rolls, 0);
    rst = 1'b0;
    m_d1 = 1;
    m_d2 = 1;
    m_rolls = 0;
    repeat (10) @(posedge clk);
    #1;
    check("midrst_idle_busy", busy, 0);

    roll(4);
    check("r4_die1", die1, 5);
    check("r4_die2", die2, 1);
    check("r4_sum", sum, 6);
    check("r4_rolls", rolls, 1);

    do_reset();
    for (int i = 0; i < 256; i++) begin
      roll(1 + (i % 3));
      if (i == 253) check("rolls_254", rolls, 254);
      if (i == 254) check("rolls_255", rolls, 255);
    end
    check("rolls_sat", rolls, 255);
    check("sat_die1", die1, m_d1);
    check("sat_die2", die2, m_d2);
    check("sat_sum", sum, m_d1 + m_d2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
